// File: rtl/sel_pkg.sv
// Shared types and defaults for the select-input debouncer.
package sel_pkg;

   // Encoding: bit 1 = debounced level, bit 0 = a level change is being qualified.
   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      CHK_PRESS = 2'd1,
      HELD      = 2'd2,
      CHK_REL   = 2'd3
   } deb_state_t;

   localparam int DEB_CYCLES_DEF = 16;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/sel_debounce.sv
// Debounces a raw button into a clean select level, a press pulse and the debounced level.
// Build option SEL_TOGGLE_EN: sel_o toggles on each accepted press instead of following the level.
module sel_debounce
   import sel_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_i,
   output logic       sel_o,
   output logic       press_o,
   output logic       btn_db_o,
   output logic [1:0] dbg_state_o
);

   localparam int CNT_W = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic             w_btn_s;
   deb_state_t       r_state;
   deb_state_t       w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_accept;
   logic             w_release;
   logic             r_press;
   logic             r_btn_db;

   sync_2ff u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (btn_i),
      .o_q   (w_btn_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // A change is accepted only after the counter has seen DEB_CYCLES more
   // matching samples beyond the one that left the stable state.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_btn_s) begin
               w_state_nxt = CHK_PRESS;
               w_cnt_nxt   = '0;
            end
         end
         CHK_PRESS: begin
            if (!w_btn_s) begin
               w_state_nxt = IDLE;
            end else if (r_cnt == CNT_MAX) begin
               w_state_nxt = HELD;
               w_accept    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (!w_btn_s) begin
               w_state_nxt = CHK_REL;
               w_cnt_nxt   = '0;
            end
         end
         CHK_REL: begin
            if (w_btn_s) begin
               w_state_nxt = HELD;
            end else if (r_cnt == CNT_MAX) begin
               w_state_nxt = IDLE;
               w_release   = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_press  <= 1'b0;
         r_btn_db <= 1'b0;
      end else begin
         r_press <= w_accept;
         if (w_accept) begin
            r_btn_db <= 1'b1;
         end else if (w_release) begin
            r_btn_db <= 1'b0;
         end
      end
   end

`ifdef SEL_TOGGLE_EN
   logic r_sel;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sel <= 1'b0;
      end else if (w_accept) begin
         r_sel <= ~r_sel;
      end
   end

   assign sel_o = r_sel;
`else
   assign sel_o = r_btn_db;
`endif

   assign press_o     = r_press;
   assign btn_db_o    = r_btn_db;
   assign dbg_state_o = r_state;

endmodule

// File: tb/tb_sel_debounce.sv
// Self-checking bench for sel_debounce: directed scenarios plus random bouncing input.
module tb_sel_debounce;
   import sel_pkg::*;

   localparam int DEB = 4;

   logic       clk;
   logic       rst_n;
   logic       btn_i;
   logic       sel_o;
   logic       press_o;
   logic       btn_db_o;
   logic [1:0] dbg_state_o;

   int total;
   int bad;
   int press_cnt;
   bit run_chk;
   logic prev_press;

   // reference model state
   logic m_s1, m_s2, m_db, m_tog, m_press;
   int   m_run;

   sel_debounce #(.DEB_CYCLES(DEB)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_i       (btn_i),
      .sel_o       (sel_o),
      .press_o     (press_o),
      .btn_db_o    (btn_db_o),
      .dbg_state_o (dbg_state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model: the debounced level flips once btn_s has differed from it on
   // DEB+1 consecutive edges; btn_s is btn_i delayed by two edges.
   always @(posedge clk or negedge rst_n) begin
      logic bs;
      if (!rst_n) begin
         m_s1 = 0; m_s2 = 0; m_db = 0; m_tog = 0; m_press = 0; m_run = 0;
      end else begin
         bs = m_s2;
         m_s2 = m_s1;
         m_s1 = btn_i;
         m_press = 0;
         if (bs != m_db) m_run++;
         else m_run = 0;
         if (m_run == DEB + 1) begin
            m_db = ~m_db;
            m_run = 0;
            if (m_db) begin
               m_press = 1;
               m_tog = ~m_tog;
            end
         end
      end
   end

   function automatic logic exp_sel();
`ifdef SEL_TOGGLE_EN
      return m_tog;
`else
      return m_db;
`endif
   endfunction

   function automatic logic [1:0] exp_state();
      if (!m_db) return (m_run == 0) ? IDLE : CHK_PRESS;
      else       return (m_run == 0) ? HELD : CHK_REL;
   endfunction

   always @(negedge clk) begin
      if (run_chk) begin
         check("press_o", press_o, m_press);
         check("btn_db_o", btn_db_o, m_db);
         check("sel_o", sel_o, exp_sel());
         check("state", dbg_state_o, exp_state());
         if (press_o && prev_press) check("press_consecutive", 1, 0);
         if (press_o) press_cnt++;
         prev_press = press_o;
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int p0;
      logic lvl;
      total = 0; bad = 0; press_cnt = 0; prev_press = 0; run_chk = 0;
      rst_n = 1'b0;
      btn_i = 1'b0;
      cycles(3);
      check("reset_press", press_o, 0);
      check("reset_db", btn_db_o, 0);
      check("reset_sel", sel_o, 0);
      check("reset_state", dbg_state_o, IDLE);
      run_chk = 1;
      #2 rst_n = 1'b1;
      cycles(5);

      // clean press: btn_i high from edge 0, pulse only after edge 6
      btn_i = 1'b1;
      cycles(6);
      check("clean_pre_press", press_o, 0);
      check("clean_pre_db", btn_db_o, 0);
      cycles(1);
      check("clean_press", press_o, 1);
      check("clean_db", btn_db_o, 1);
      check("clean_sel", sel_o, 1);
      cycles(1);
      check("clean_press_one", press_o, 0);
      cycles(12);
      btn_i = 1'b0;
      cycles(20);
      check("clean_released", btn_db_o, 0);

      // bounce reject
      p0 = press_cnt;
      btn_i = 1; cycles(3);
      btn_i = 0; cycles(1);
      btn_i = 1; cycles(2);
      btn_i = 0; cycles(12);
      check("bounce_presses", press_cnt - p0, 0);
      check("bounce_db", btn_db_o, 0);
      check("bounce_state", dbg_state_o, IDLE);

      // toggle sequence from a fresh reset
      do_reset();
      cycles(3);
      p0 = press_cnt;
      for (int i = 0; i < 3; i++) begin
         btn_i = 1; cycles(12);
`ifdef SEL_TOGGLE_EN
         check("toggle_sel", sel_o, (i % 2 == 0) ? 1 : 0);
`else
         check("toggle_sel", sel_o, 1);
`endif
         btn_i = 0; cycles(12);
      end
      check("toggle_presses", press_cnt - p0, 3);

      // release bounce while held
      p0 = press_cnt;
      btn_i = 1; cycles(10);
      btn_i = 0; cycles(2);
      btn_i = 1; cycles(10);
      check("relbounce_db", btn_db_o, 1);
      check("relbounce_presses", press_cnt - p0, 1);
      btn_i = 0; cycles(12);

      // reset during CHK_PRESS at cnt=2
      btn_i = 1;
      cycles(5);
      check("mid_state", dbg_state_o, CHK_PRESS);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_press", press_o, 0);
      check("mid_rst_db", btn_db_o, 0);
      check("mid_rst_sel", sel_o, 0);
      check("mid_rst_state", dbg_state_o, IDLE);
      @(negedge clk);
      #2 rst_n = 1'b1;
      cycles(6);
      check("mid_pre_press", press_o, 0);
      cycles(1);
      check("mid_press", press_o, 1);

      // held through reset release
      @(negedge clk);
      #2 rst_n = 1'b0;
      cycles(3);
      #2 rst_n = 1'b1;
      p0 = press_cnt;
      cycles(6);
      check("held_pre_press", press_o, 0);
      cycles(1);
      check("held_press", press_o, 1);
      cycles(20);
      check("held_single", press_cnt - p0, 1);
      btn_i = 0; cycles(12);

      // random bouncing input with occasional resets
      lvl = 0;
      for (int seg = 0; seg < 400; seg++) begin
         lvl = ($urandom_range(0, 3) == 0) ? lvl : ~lvl;
         btn_i = lvl;
         cycles($urandom_range(1, 12));
         if ($urandom_range(0, 49) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk);
            #2 rst_n = 1'b1;
         end
      end
      btn_i = 0;
      cycles(12);
      check("final_db", btn_db_o, 0);

      run_chk = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
